// File: rtl/isqrt_pkg.sv
`default_nettype none
// ============================================================================
// isqrt_pkg : state encoding and width helpers shared by isqrt_seq/isqrt_dp
// Rev 1.0
// ============================================================================
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Running square must hold 2^W when din = 2^W-1.
  function automatic int sq_width(input int w);
    return w + 1;
  endfunction

  // Odd step reaches 2*(2^(W/2))+1 on the final compare.
  function automatic int del_width(input int w);
    return w / 2 + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/isqrt_dp.sv
`default_nettype none
// ============================================================================
// isqrt_dp : radicand, running-square and odd-step registers with compare.
// Remainder term only with ISQRT_REM_EN. Rev 1.0
// ============================================================================
module isqrt_dp
  import isqrt_pkg::*;
#(
  parameter int W = 16,
  localparam int DW = del_width(W)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          load,
  input  logic          step,
  input  logic [W-1:0]  din,
  output logic          gt,
  output logic [DW-1:0] del
`ifdef ISQRT_REM_EN
  ,
  output logic [W:0]    rem_next
`endif
);

  localparam int SW = sq_width(W);

  logic [W-1:0]  a_q,   a_d;
  logic [SW-1:0] sq_q,  sq_d;
  logic [DW-1:0] del_q, del_d;

  always_comb begin
    a_d   = a_q;
    sq_d  = sq_q;
    del_d = del_q;
    if (load) begin
      a_d   = din;
      sq_d  = SW'(1);
      del_d = DW'(3);
    end else if (step) begin
      sq_d  = sq_q + SW'(del_q);
      del_d = del_q + DW'(2);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      a_q   <= '0;
      sq_q  <= '0;
      del_q <= '0;
    end else begin
      a_q   <= a_d;
      sq_q  <= sq_d;
      del_q <= del_d;
    end
  end

  assign gt  = sq_q > {1'b0, a_q};
  assign del = del_q;

`ifdef ISQRT_REM_EN
  // sq - (del-2) is the previous square, i.e. root^2 once gt is seen.
  assign rem_next = {1'b0, a_q} - (sq_q - SW'(del_q - DW'(2)));
`endif

endmodule
`default_nettype wire

// File: rtl/isqrt_seq.sv
`default_nettype none
// ============================================================================
// isqrt_seq : sequential floor(sqrt(din)) by odd-number summation with a
// start/busy/done handshake. ISQRT_REM_EN adds the rem output. Rev 1.0
// ============================================================================
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           start,
  input  logic [W-1:0]   din,
  output logic           busy,
  output logic           done,
  output logic [W/2-1:0] root
`ifdef ISQRT_REM_EN
  ,
  output logic [W:0]     rem
`endif
);

  localparam int RW = W / 2;
  localparam int DW = del_width(W);

  state_e        state_q, state_d;
  logic          load, step, gt;
  logic [DW-1:0] del;
  logic [RW-1:0] root_q, root_d;
`ifdef ISQRT_REM_EN
  logic [W:0]    rem_q, rem_d, rem_next;
`endif

  isqrt_dp #(.W(W)) u_dp (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (load),
    .step     (step),
    .din      (din),
    .gt       (gt),
    .del      (del)
`ifdef ISQRT_REM_EN
    ,
    .rem_next (rem_next)
`endif
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    root_d  = root_q;
`ifdef ISQRT_REM_EN
    rem_d   = rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (gt) begin
          // (del-2)>>1 equals (del>>1)-1 for the odd del values seen here
          root_d  = RW'((del - DW'(2)) >> 1);
`ifdef ISQRT_REM_EN
          rem_d   = rem_next;
`endif
          state_d = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      root_q  <= '0;
`ifdef ISQRT_REM_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      root_q  <= root_d;
`ifdef ISQRT_REM_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign root = root_q;
`ifdef ISQRT_REM_EN
  assign rem  = rem_q;
`endif

endmodule
`default_nettype wire
